// File: rtl/sigmoid_pkg.sv
// Shared widths, fixed-point unity constants and scheduler state encoding
// for the output-layer sigmoid sharing logic.
package sigmoid_pkg;

  localparam int SIG_IN_W    = 32;
  localparam int SIG_OUT_W   = 16;
  localparam int SIG_ONE_IN  = 16777216;
  localparam int SIG_ONE_OUT = 4096;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    LOOKUP,
    OUTPUT
  } sched_state_t;

endpackage

// File: rtl/sigmoid_scheduler_rr_priority_select.sv
// Round-robin priority search: first set candidate at or above the pointer,
// wrapping from NUM_REQ-1 back to 0.
module rr_priority_select #(
  parameter  int NUM_REQ = 10,
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] cand_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic               found_o,
  output logic [IDX_W-1:0]   winner_o
);

  localparam int unsigned NR = NUM_REQ;

  always_comb begin
    int unsigned idx;
    idx      = 0;
    found_o  = 1'b0;
    winner_o = '0;
    for (int unsigned k = 0; k < NR; k++) begin
      idx = int'(ptr_i) + k;
      if (idx >= NR) idx = idx - NR;
      if (!found_o && (idx < NR) && cand_i[idx[IDX_W-1:0]]) begin
        found_o  = 1'b1;
        winner_o = idx[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/sigmoid_scheduler.sv
// Shares one external combinational sigmoid unit among NUM_REQ accumulators,
// serving each requester once per frame in round-robin order.
module sigmoid_scheduler
  import sigmoid_pkg::*;
#(
  parameter  int NUM_REQ = 10,
  parameter  int IN_W    = SIG_IN_W,
  parameter  int OUT_W   = SIG_OUT_W,
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*IN_W-1:0] req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [IN_W-1:0]         sig_in,
  input  logic [OUT_W-1:0]        sig_out,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [OUT_W-1:0]        res_data,
  output logic [IDX_W-1:0]        res_idx,
  output logic                    busy,
  output logic                    frame_done
);

  sched_state_t       state_q, state_d;
  logic [NUM_REQ-1:0] served_q, served_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IN_W-1:0]    sig_in_q, sig_in_d;
  logic               res_valid_q, res_valid_d;
  logic [OUT_W-1:0]   res_data_q, res_data_d;
  logic [IDX_W-1:0]   res_idx_q, res_idx_d;
  logic               frame_done_q, frame_done_d;

  logic [NUM_REQ-1:0] cand;
  logic               found;
  logic [IDX_W-1:0]   winner;
  logic [IN_W-1:0]    operand [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign operand[g] = req_data[g*IN_W +: IN_W];
  end

  assign cand = req_valid & ~served_q;

  rr_priority_select #(
    .NUM_REQ (NUM_REQ)
  ) u_select (
    .cand_i   (cand),
    .ptr_i    (ptr_q),
    .found_o  (found),
    .winner_o (winner)
  );

  always_comb begin
    state_d      = state_q;
    served_d     = served_q;
    ptr_d        = ptr_q;
    sig_in_d     = sig_in_q;
    res_valid_d  = res_valid_q;
    res_data_d   = res_data_q;
    res_idx_d    = res_idx_q;
    frame_done_d = 1'b0;
    req_ready    = '0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          served_d = '0;
          state_d  = GRANT;
        end
      end
      GRANT: begin
        if (found) begin
          req_ready        = NUM_REQ'(1) << winner;
          sig_in_d         = operand[winner];
          res_idx_d        = winner;
          served_d[winner] = 1'b1;
          ptr_d            = (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + IDX_W'(1);
          state_d          = LOOKUP;
        end
      end
      LOOKUP: begin
        res_data_d  = sig_out;
        res_valid_d = 1'b1;
        state_d     = OUTPUT;
      end
      OUTPUT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          // served_q already includes the requester being drained here
          if (&served_q) begin
            frame_done_d = 1'b1;
            state_d      = IDLE;
          end else begin
            state_d = GRANT;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      served_q     <= '0;
      ptr_q        <= '0;
      sig_in_q     <= '0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_idx_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      served_q     <= served_d;
      ptr_q        <= ptr_d;
      sig_in_q     <= sig_in_d;
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
      res_idx_q    <= res_idx_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign sig_in     = sig_in_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign res_idx    = res_idx_q;
  assign busy       = (state_q != IDLE);
  assign frame_done = frame_done_q;

endmodule
